// File: rtl/ldst_mem_port_arbiter.sv
// rtl/ldst_mem_port_arbiter.sv - uncached memory port arbiter between LSU loads and a committed-store write buffer
module ldst_mem_port_arbiter #(
    parameter int ST_BUF_DEPTH = 4,
    parameter int ADDR_BITS    = 64,
    parameter int DATA_BITS    = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recover_i,
    input  logic                 ld_req_i,
    input  logic [ADDR_BITS-1:0] ld_addr_i,
    output logic                 ld_ack_o,
    output logic [DATA_BITS-1:0] ld_data_o,
    output logic                 ld_data_valid_o,
    input  logic                 st_req_i,
    input  logic [ADDR_BITS-1:0] st_addr_i,
    input  logic [DATA_BITS-1:0] st_data_i,
    input  logic [7:0]           st_be_i,
    output logic                 st_ack_o,
    output logic                 st_buf_full_o,
    input  logic                 drain_i,
    output logic                 drained_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [DATA_BITS-1:0] mem_wdata_o,
    output logic [7:0]           mem_be_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [DATA_BITS-1:0] mem_rdata_i
);
    localparam int PTR_W = $clog2(ST_BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = ADDR_BITS - 3;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ST_BUF_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]     buf_tag  [ST_BUF_DEPTH];
    logic [DATA_BITS-1:0] buf_data [ST_BUF_DEPTH];
    logic [7:0]           buf_be   [ST_BUF_DEPTH];
    logic [ST_BUF_DEPTH-1:0] buf_valid;
    logic [PTR_W-1:0]     head_q, tail_q;
    logic [CNT_W-1:0]     count_q;
    logic                 squash_q;

    logic             push, pop, hazard, ld_start, st_start;
    logic [TAG_W-1:0] ld_tag, st_tag;
    logic             unused_addr_bits;

    assign ld_tag           = ld_addr_i[ADDR_BITS-1:3];
    assign st_tag           = st_addr_i[ADDR_BITS-1:3];
    assign unused_addr_bits = ^{ld_addr_i[2:0], st_addr_i[2:0]};

    assign st_buf_full_o = (count_q == FULL_CNT);
    assign st_ack_o      = st_req_i & ~st_buf_full_o;
    assign push          = st_ack_o;
    assign pop           = (state_q == ST_WAIT) & mem_rvalid_i;
    assign drained_o     = (count_q == '0) && (state_q != ST_REQ) && (state_q != ST_WAIT);

    // A load may not overtake any buffered store to the same doubleword,
    // including the one being accepted right now; byte enables are ignored.
    always_comb begin
        hazard = st_ack_o && (st_tag == ld_tag);
        for (int i = 0; i < ST_BUF_DEPTH; i++) begin
            if (buf_valid[i] && (buf_tag[i] == ld_tag)) begin
                hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_tag[tail_q]  <= st_tag;
            buf_data[tail_q] <= st_data_i;
            buf_be[tail_q]   <= st_be_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            buf_valid <= '0;
        end else begin
            if (push) begin
                tail_q            <= tail_q + PTR_W'(1);
                buf_valid[tail_q] <= 1'b1;
            end
            if (pop) begin
                head_q            <= head_q + PTR_W'(1);
                buf_valid[head_q] <= 1'b0;
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_ack_o = 1'b0;
        ld_start = 1'b0;
        st_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (st_buf_full_o) begin
                    st_start = 1'b1;
                    state_d  = ST_REQ;
                end else if (ld_req_i && !hazard && !drain_i && !recover_i) begin
                    ld_ack_o = 1'b1;
                    ld_start = 1'b1;
                    state_d  = LD_REQ;
                end else if (count_q != '0) begin
                    st_start = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            LD_REQ: begin
                if (mem_gnt_i) begin
                    state_d = LD_WAIT;
                end else if (recover_i) begin
                    state_d = IDLE;
                end
            end
            LD_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory request fields are loaded when leaving IDLE and held until the grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req_o       <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= '0;
            mem_wdata_o     <= '0;
            mem_be_o        <= '0;
            ld_data_o       <= '0;
            ld_data_valid_o <= 1'b0;
            squash_q        <= 1'b0;
        end else begin
            ld_data_valid_o <= 1'b0;
            if (ld_start) begin
                mem_req_o  <= 1'b1;
                mem_we_o   <= 1'b0;
                mem_addr_o <= {ld_tag, 3'b000};
                mem_be_o   <= 8'hFF;
            end else if (st_start) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b1;
                mem_addr_o  <= {buf_tag[head_q], 3'b000};
                mem_wdata_o <= buf_data[head_q];
                mem_be_o    <= buf_be[head_q];
            end else if (((state_q == LD_REQ || state_q == ST_REQ) && mem_gnt_i) ||
                         (state_q == LD_REQ && recover_i)) begin
                mem_req_o <= 1'b0;
            end

            if (state_d == IDLE) begin
                squash_q <= 1'b0;
            end else if (recover_i && ((state_q == LD_REQ && mem_gnt_i) || state_q == LD_WAIT)) begin
                squash_q <= 1'b1;
            end

            if (state_q == LD_WAIT && mem_rvalid_i) begin
                ld_data_o       <= mem_rdata_i;
                ld_data_valid_o <= ~(squash_q | recover_i);
            end
        end
    end
endmodule

// File: tb/tb_ldst_mem_port_arbiter.sv
// tb/tb_ldst_mem_port_arbiter.sv - directed self-checking bench for ldst_mem_port_arbiter
module tb_ldst_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        recover_i;
    logic        ld_req_i;
    logic [63:0] ld_addr_i;
    logic        ld_ack_o;
    logic [63:0] ld_data_o;
    logic        ld_data_valid_o;
    logic        st_req_i;
    logic [63:0] st_addr_i;
    logic [63:0] st_data_i;
    logic [7:0]  st_be_i;
    logic        st_ack_o;
    logic        st_buf_full_o;
    logic        drain_i;
    logic        drained_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;

    int errors = 0;
    int checks = 0;

    ldst_mem_port_arbiter dut (
        .clk(clk), .reset(reset), .recover_i(recover_i),
        .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_ack_o(ld_ack_o),
        .ld_data_o(ld_data_o), .ld_data_valid_o(ld_data_valid_o),
        .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
        .st_be_i(st_be_i), .st_ack_o(st_ack_o), .st_buf_full_o(st_buf_full_o),
        .drain_i(drain_i), .drained_o(drained_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] sa(int k);
        return 64'h4000 + 64'(k) * 64'd8;
    endfunction
    function automatic logic [63:0] sd(int k);
        return 64'hA5A5_0000_0000_0000 | 64'(k);
    endfunction
    function automatic logic [7:0] sb(int k);
        return 8'(1 << (k % 8));
    endfunction

    task automatic drive_store(int k);
        st_req_i  = 1'b1;
        st_addr_i = sa(k);
        st_data_i = sd(k);
        st_be_i   = sb(k);
    endtask

    task automatic check_write(string tag, int k);
        chk({tag, "_req"},   {63'd0, mem_req_o}, 64'd1);
        chk({tag, "_we"},    {63'd0, mem_we_o},  64'd1);
        chk({tag, "_addr"},  mem_addr_o,         sa(k));
        chk({tag, "_wdata"}, mem_wdata_o,        sd(k));
        chk({tag, "_be"},    {56'd0, mem_be_o},  {56'd0, sb(k)});
    endtask

    initial begin
        reset = 1'b0; recover_i = 0; ld_req_i = 0; ld_addr_i = 0;
        st_req_i = 0; st_addr_i = 0; st_data_i = 0; st_be_i = 0;
        drain_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        #2;
        chk("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
        chk("rst_mem_be", {56'd0, mem_be_o}, 64'd0);
        chk("rst_drained", {63'd0, drained_o}, 64'd1);
        chk("rst_ld_valid", {63'd0, ld_data_valid_o}, 64'd0);
        chk("rst_full", {63'd0, st_buf_full_o}, 64'd0);
        #4 reset = 1'b1;
        cyc();

        // single load: ack, request, grant, rvalid, data
        ld_req_i = 1; ld_addr_i = 64'h1004; #1;
        chk("t1_ack", {63'd0, ld_ack_o}, 64'd1);
        cyc();
        ld_req_i = 0; mem_gnt_i = 1; #1;
        chk("t1_req", {63'd0, mem_req_o}, 64'd1);
        chk("t1_we", {63'd0, mem_we_o}, 64'd0);
        chk("t1_addr", mem_addr_o, 64'h1000);
        chk("t1_be", {56'd0, mem_be_o}, 64'hFF);
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'hDEADBEEF_CAFEF00D; #1;
        chk("t1_req_drop", {63'd0, mem_req_o}, 64'd0);
        chk("t1_valid_early", {63'd0, ld_data_valid_o}, 64'd0);
        cyc();
        mem_rvalid_i = 0; #1;
        chk("t1_valid", {63'd0, ld_data_valid_o}, 64'd1);
        chk("t1_data", ld_data_o, 64'hDEADBEEF_CAFEF00D);
        cyc();
        chk("t1_valid_pulse", {63'd0, ld_data_valid_o}, 64'd0);

        // priority and hazard
        st_req_i = 1; st_addr_i = 64'h2000; st_data_i = 64'h1111_2222_3333_4444; st_be_i = 8'h0F; #1;
        chk("t2_st_ack", {63'd0, st_ack_o}, 64'd1);
        cyc();
        st_req_i = 0; ld_req_i = 1; ld_addr_i = 64'h3000; #1;
        chk("t2_ld_prio", {63'd0, ld_ack_o}, 64'd1);
        cyc();
        ld_req_i = 0; mem_gnt_i = 1; #1;
        chk("t2_ld_we", {63'd0, mem_we_o}, 64'd0);
        chk("t2_ld_addr", mem_addr_o, 64'h3000);
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'h3333; cyc();
        mem_rvalid_i = 0; ld_req_i = 1; ld_addr_i = 64'h2006; #1;
        chk("t2_hazard_noack", {63'd0, ld_ack_o}, 64'd0);
        cyc();
        mem_gnt_i = 1; #1;
        chk("t2_st_we", {63'd0, mem_we_o}, 64'd1);
        chk("t2_st_addr", mem_addr_o, 64'h2000);
        chk("t2_st_wdata", mem_wdata_o, 64'h1111_2222_3333_4444);
        chk("t2_st_be", {56'd0, mem_be_o}, 64'h0F);
        chk("t2_noack_streq", {63'd0, ld_ack_o}, 64'd0);
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; #1;
        chk("t2_noack_stwait", {63'd0, ld_ack_o}, 64'd0);
        chk("t2_not_drained", {63'd0, drained_o}, 64'd0);
        cyc();
        mem_rvalid_i = 0; #1;
        chk("t2_ack_after", {63'd0, ld_ack_o}, 64'd1);
        chk("t2_drained", {63'd0, drained_o}, 64'd1);
        cyc();
        ld_req_i = 0; mem_gnt_i = 1; #1;
        chk("t2_ld2_addr", mem_addr_o, 64'h2000);
        chk("t2_ld2_we", {63'd0, mem_we_o}, 64'd0);
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'h2222; cyc();
        mem_rvalid_i = 0; #1;
        chk("t2_ld2_data", ld_data_o, 64'h2222);
        cyc();

        // full buffer, FIFO order, pointer wrap over 10 stores
        ld_req_i = 1; ld_addr_i = 64'h5000; #1;
        chk("t3_ld_ack", {63'd0, ld_ack_o}, 64'd1);
        cyc();
        ld_req_i = 0; mem_gnt_i = 1; cyc();
        mem_gnt_i = 0;
        for (int k = 0; k < 4; k++) begin
            drive_store(k); #1;
            chk($sformatf("t3_push%0d", k), {63'd0, st_ack_o}, 64'd1);
            cyc();
        end
        drive_store(4); mem_rvalid_i = 1; mem_rdata_i = 64'h5555; ld_req_i = 1; ld_addr_i = 64'h6000; #1;
        chk("t3_full", {63'd0, st_buf_full_o}, 64'd1);
        chk("t3_st5_noack", {63'd0, st_ack_o}, 64'd0);
        cyc();
        mem_rvalid_i = 0; #1;
        chk("t3_ld_blocked_full", {63'd0, ld_ack_o}, 64'd0);
        chk("t3_st5_noack_idle", {63'd0, st_ack_o}, 64'd0);
        chk("t3_ld_valid", {63'd0, ld_data_valid_o}, 64'd1);
        chk("t3_ld_data", ld_data_o, 64'h5555);
        cyc();
        check_write("t3_w0_hold", 0);
        cyc();
        mem_gnt_i = 1; #1;
        check_write("t3_w0", 0);
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; #1;
        chk("t3_full_stwait", {63'd0, st_buf_full_o}, 64'd1);
        chk("t3_st5_noack_wait", {63'd0, st_ack_o}, 64'd0);
        cyc();
        mem_rvalid_i = 0; #1;
        chk("t3_slot_open", {63'd0, st_buf_full_o}, 64'd0);
        chk("t3_st5_ack", {63'd0, st_ack_o}, 64'd1);
        chk("t3_ld_ack_after_pop", {63'd0, ld_ack_o}, 64'd1);
        cyc();
        st_req_i = 0; ld_req_i = 0; mem_gnt_i = 1; #1;
        chk("t3_full_again", {63'd0, st_buf_full_o}, 64'd1);
        chk("t3_ld6_addr", mem_addr_o, 64'h6000);
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'h6666; cyc();
        mem_rvalid_i = 0; cyc();
        mem_gnt_i = 1; #1;
        check_write("t3_w1", 1);
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; cyc();
        mem_rvalid_i = 0; #1;
        chk("t3_cnt3_notfull", {63'd0, st_buf_full_o}, 64'd0);
        cyc();
        mem_gnt_i = 1; #1;
        check_write("t3_w2", 2);
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; drive_store(5); #1;
        chk("t3_pushpop_ack", {63'd0, st_ack_o}, 64'd1);
        cyc();
        mem_rvalid_i = 0; #1;
        chk("t3_pushpop_notfull", {63'd0, st_buf_full_o}, 64'd0);
        drive_store(6); #1;
        chk("t3_push6_ack", {63'd0, st_ack_o}, 64'd1);
        cyc();
        st_req_i = 0; mem_gnt_i = 1; #1;
        chk("t3_pushpop_kept", {63'd0, st_buf_full_o}, 64'd1);
        check_write("t3_w3", 3);
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; cyc();
        mem_rvalid_i = 0;
        for (int j = 4; j < 10; j++) begin
            if (j <= 6) begin
                drive_store(j + 3); #1;
                chk($sformatf("t3_push%0d", j + 3), {63'd0, st_ack_o}, 64'd1);
            end
            cyc();
            st_req_i = 0; mem_gnt_i = 1; #1;
            check_write($sformatf("t3_w%0d", j), j);
            cyc();
            mem_gnt_i = 0; mem_rvalid_i = 1; cyc();
            mem_rvalid_i = 0;
        end
        #1;
        chk("t3_drained", {63'd0, drained_o}, 64'd1);
        cyc();

        // recover: (a) before grant, (b) during LD_WAIT
        recover_i = 1; ld_req_i = 1; ld_addr_i = 64'h7000; #1;
        chk("t4_recover_noack", {63'd0, ld_ack_o}, 64'd0);
        recover_i = 0; #1;
        chk("t4a_ack", {63'd0, ld_ack_o}, 64'd1);
        cyc();
        ld_req_i = 0; recover_i = 1; #1;
        chk("t4a_req", {63'd0, mem_req_o}, 64'd1);
        cyc();
        recover_i = 0; #1;
        chk("t4a_req_drop", {63'd0, mem_req_o}, 64'd0);
        ld_req_i = 1; ld_addr_i = 64'h7008; #1;
        chk("t4a_idle_ack", {63'd0, ld_ack_o}, 64'd1);
        cyc();
        ld_req_i = 0; mem_gnt_i = 1; cyc();
        mem_gnt_i = 0; recover_i = 1; cyc();
        recover_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'hBAD0; cyc();
        mem_rvalid_i = 0; #1;
        chk("t4b_suppressed", {63'd0, ld_data_valid_o}, 64'd0);
        ld_req_i = 1; ld_addr_i = 64'h7010; #1;
        chk("t4b_next_ack", {63'd0, ld_ack_o}, 64'd1);
        cyc();
        ld_req_i = 0; mem_gnt_i = 1; cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'h7777; cyc();
        mem_rvalid_i = 0; #1;
        chk("t4b_next_valid", {63'd0, ld_data_valid_o}, 64'd1);
        chk("t4b_next_data", ld_data_o, 64'h7777);
        cyc();

        // drain / fence
        st_req_i = 1; st_addr_i = 64'h8000; st_data_i = 64'hB0; st_be_i = 8'hFF; cyc();
        st_addr_i = 64'h8008; st_data_i = 64'hB1; st_be_i = 8'hF0; #1;
        chk("t5_push_b", {63'd0, st_ack_o}, 64'd1);
        cyc();
        st_req_i = 0; drain_i = 1; ld_req_i = 1; ld_addr_i = 64'h9000; mem_gnt_i = 1; #1;
        chk("t5_wa_addr", mem_addr_o, 64'h8000);
        chk("t5_not_drained", {63'd0, drained_o}, 64'd0);
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; cyc();
        mem_rvalid_i = 0; #1;
        chk("t5_drain_noack", {63'd0, ld_ack_o}, 64'd0);
        cyc();
        mem_gnt_i = 1; #1;
        chk("t5_wb_addr", mem_addr_o, 64'h8008);
        chk("t5_wb_data", mem_wdata_o, 64'hB1);
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; #1;
        chk("t5_not_drained2", {63'd0, drained_o}, 64'd0);
        cyc();
        mem_rvalid_i = 0; #1;
        chk("t5_drained", {63'd0, drained_o}, 64'd1);
        chk("t5_held_noack", {63'd0, ld_ack_o}, 64'd0);
        cyc();
        drain_i = 0; #1;
        chk("t5_ack_after_drain", {63'd0, ld_ack_o}, 64'd1);
        cyc();
        ld_req_i = 0; mem_gnt_i = 1; #1;
        chk("t5_ld_addr", mem_addr_o, 64'h9000);
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'h9999; cyc();
        mem_rvalid_i = 0; #1;
        chk("t5_ld_valid", {63'd0, ld_data_valid_o}, 64'd1);
        cyc();

        // asynchronous reset in ST_WAIT
        st_req_i = 1; st_addr_i = 64'hC000; st_data_i = 64'hC0; st_be_i = 8'h3C; cyc();
        st_req_i = 0; cyc();
        mem_gnt_i = 1; cyc();
        mem_gnt_i = 0; #1;
        chk("t6_pre_drained", {63'd0, drained_o}, 64'd0);
        #2 reset = 1'b0; #1;
        chk("t6_req", {63'd0, mem_req_o}, 64'd0);
        chk("t6_be", {56'd0, mem_be_o}, 64'd0);
        chk("t6_we", {63'd0, mem_we_o}, 64'd0);
        chk("t6_addr", mem_addr_o, 64'd0);
        chk("t6_drained", {63'd0, drained_o}, 64'd1);
        chk("t6_full", {63'd0, st_buf_full_o}, 64'd0);
        #1 reset = 1'b1; mem_rvalid_i = 1; mem_rdata_i = 64'hDEAD;
        cyc();
        mem_rvalid_i = 0; #1;
        chk("t6_late_rvalid", {63'd0, ld_data_valid_o}, 64'd0);
        chk("t6_idle_drained", {63'd0, drained_o}, 64'd1);
        chk("t6_idle_noreq", {63'd0, mem_req_o}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
